// File: rtl/port_rst_sequencer.sv
// -----------------------------------------------------------------------------
// port_rst_sequencer
//
// Per-port soft-reset sequencer for the port gasket. Turns a level reset
// request from each port's control CSR into a clean active-low reset for the
// downstream AFU. Before the reset is asserted, any TX A packet already in
// flight is allowed to finish, so the AFU never sees reset in the middle of a
// TLP. After the reset is released, new packet starts stay blocked for a
// short gap. Every port runs its own independent state machine.
//
// Per-port sequence: RUN -> DRAIN -> RESET -> HOLD -> RELEASE -> RUN.
// Coming out of rst_n every port starts in RESET, so it is held in reset for
// RESET_HOLD_CYCLES and then released if no request is pending.
//
// Optional feature (compile-time macro PORT_RST_DRAIN_TIMEOUT_EN):
//   defined   - DRAIN gives up after DRAIN_TIMEOUT_CYCLES with a packet still
//               open, forces the reset and raises the sticky drain_timeout_o.
//   undefined - DRAIN waits indefinitely, drain_timeout_o is tied to 0 and no
//               drain counter exists.
//
// Parameters:
//   PG_NUM_PORTS         number of independent AFU ports
//   RESET_HOLD_CYCLES    minimum cycles port_rst_n_o stays low (>= 1)
//   RELEASE_GAP_CYCLES   cycles tx_block_o stays high after release (>= 1)
//   DRAIN_TIMEOUT_CYCLES DRAIN limit before a forced reset (optional feature)
//
// Ports (all vectors are one bit per port):
//   clk               clock; all logic is synchronous to it
//   rst_n             asynchronous active-low reset
//   port_reset_req_i  level request from the port CSR, 1 = hold port in reset
//   tx_a_tvalid_i     TX A tvalid observed at the AFU boundary
//   tx_a_tready_i     TX A tready
//   tx_a_tlast_i      TX A tlast
//   port_rst_n_o      active-low reset to each AFU port (registered)
//   tx_block_o        1 = downstream gate refuses new packet starts (registered)
//   port_reset_ack_o  1 = port held in reset and request still high (registered)
//   drain_timeout_o   sticky flag: DRAIN hit the timeout (registered)
// -----------------------------------------------------------------------------
module port_rst_sequencer #(
    parameter int PG_NUM_PORTS         = 1,
    parameter int RESET_HOLD_CYCLES    = 64,
    parameter int RELEASE_GAP_CYCLES   = 8,
    parameter int DRAIN_TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PG_NUM_PORTS-1:0] port_reset_req_i,
    input  logic [PG_NUM_PORTS-1:0] tx_a_tvalid_i,
    input  logic [PG_NUM_PORTS-1:0] tx_a_tready_i,
    input  logic [PG_NUM_PORTS-1:0] tx_a_tlast_i,
    output logic [PG_NUM_PORTS-1:0] port_rst_n_o,
    output logic [PG_NUM_PORTS-1:0] tx_block_o,
    output logic [PG_NUM_PORTS-1:0] port_reset_ack_o,
    output logic [PG_NUM_PORTS-1:0] drain_timeout_o
);

    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(RELEASE_GAP_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_RESET,
        ST_HOLD,
        ST_RELEASE
    } state_e;

    // Reject parameter values that would make a counter compare never match.
    if (RESET_HOLD_CYCLES < 1 || RELEASE_GAP_CYCLES < 1 || DRAIN_TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("port_rst_sequencer: cycle-count parameters must be >= 1");
    end

    for (genvar gi = 0; gi < PG_NUM_PORTS; gi++) begin : g_port
        state_e              state_q, state_d;
        logic                in_pkt_q, in_pkt_d;
        logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
        logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
        logic                port_rst_n_q, port_rst_n_d;
        logic                tx_block_q, tx_block_d;
        logic                ack_q, ack_d;
        logic                beat;
        logic                drain_done;
        logic                drain_expired;

        assign beat = tx_a_tvalid_i[gi] & tx_a_tready_i[gi];

        // DRAIN may finish when no packet is open and nothing moves this
        // cycle, or when this cycle's beat closes the packet.
        assign drain_done = beat ? tx_a_tlast_i[gi] : ~in_pkt_q;

        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            gap_cnt_d  = gap_cnt_q;
            in_pkt_d   = beat ? ~tx_a_tlast_i[gi] : in_pkt_q;

            case (state_q)
                ST_RUN: begin
                    if (port_reset_req_i[gi]) begin
                        state_d = ST_DRAIN;
                    end
                end
                // A request drop here does not abort: once draining has
                // started the full reset sequence always completes.
                ST_DRAIN: begin
                    if (drain_done || drain_expired) begin
                        state_d    = ST_RESET;
                        hold_cnt_d = '0;
                    end
                end
                ST_RESET: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_HOLD;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!port_reset_req_i[gi]) begin
                        state_d   = ST_RELEASE;
                        gap_cnt_d = '0;
                    end
                end
                // A request arriving here is serviced only after the gap,
                // from RUN, so the AFU always gets its full release gap.
                ST_RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_RUN;
                    end else if (gap_cnt_q != '1) begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_RESET;
                    hold_cnt_d = '0;
                end
            endcase

            // The AFU is about to be reset: any partial packet is discarded.
            if (state_d == ST_RESET && state_q != ST_RESET) begin
                in_pkt_d = 1'b0;
            end

            // Outputs are registered from the next state so they change in
            // the same cycle the state does.
            port_rst_n_d = !(state_d == ST_RESET || state_d == ST_HOLD);
            tx_block_d   = (state_d != ST_RUN);
            ack_d        = (state_d == ST_HOLD) && port_reset_req_i[gi];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q      <= ST_RESET;
                in_pkt_q     <= 1'b0;
                hold_cnt_q   <= '0;
                gap_cnt_q    <= '0;
                port_rst_n_q <= 1'b0;
                tx_block_q   <= 1'b1;
                ack_q        <= 1'b0;
            end else begin
                state_q      <= state_d;
                in_pkt_q     <= in_pkt_d;
                hold_cnt_q   <= hold_cnt_d;
                gap_cnt_q    <= gap_cnt_d;
                port_rst_n_q <= port_rst_n_d;
                tx_block_q   <= tx_block_d;
                ack_q        <= ack_d;
            end
        end

        assign port_rst_n_o[gi]     = port_rst_n_q;
        assign tx_block_o[gi]       = tx_block_q;
        assign port_reset_ack_o[gi] = ack_q;

`ifdef PORT_RST_DRAIN_TIMEOUT_EN
        localparam int DRN_W = $clog2(DRAIN_TIMEOUT_CYCLES + 1);
        localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT_CYCLES - 1);

        logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
        logic             drain_timeout_q, drain_timeout_d;

        // The counter is parked at zero in RUN so DRAIN always starts fresh.
        assign drain_expired = (state_q == ST_DRAIN) && (drain_cnt_q == DRN_LAST);

        always_comb begin
            drain_cnt_d     = drain_cnt_q;
            drain_timeout_d = drain_timeout_q;
            if (state_q == ST_RUN) begin
                drain_cnt_d = '0;
            end else if (state_q == ST_DRAIN && drain_cnt_q != '1) begin
                drain_cnt_d = drain_cnt_q + 1'b1;
            end
            // Flag only a genuine timeout, not a drain that happened to
            // complete on the final counted cycle.
            if (drain_expired && !drain_done) begin
                drain_timeout_d = 1'b1;
            end else if (state_q == ST_RELEASE && state_d == ST_RUN) begin
                drain_timeout_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drain_cnt_q     <= '0;
                drain_timeout_q <= 1'b0;
            end else begin
                drain_cnt_q     <= drain_cnt_d;
                drain_timeout_q <= drain_timeout_d;
            end
        end

        assign drain_timeout_o[gi] = drain_timeout_q;
`else
        assign drain_expired       = 1'b0;
        assign drain_timeout_o[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_port_rst_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for port_rst_sequencer with two ports, HOLD=64, GAP=8,
// TIMEOUT=16. Cycle k of a step means "k rising edges after the inputs were
// set"; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_port_rst_sequencer;

    localparam int NP   = 2;
    localparam int HOLD = 64;
    localparam int GAP  = 8;
    localparam int TMO  = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] req   = '0;
    logic [NP-1:0] tv    = '0;
    logic [NP-1:0] tr    = '0;
    logic [NP-1:0] tl    = '0;
    wire  [NP-1:0] prst_n;
    wire  [NP-1:0] blk;
    wire  [NP-1:0] ack;
    wire  [NP-1:0] dto;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    port_rst_sequencer #(
        .PG_NUM_PORTS        (NP),
        .RESET_HOLD_CYCLES   (HOLD),
        .RELEASE_GAP_CYCLES  (GAP),
        .DRAIN_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .port_reset_req_i(req),
        .tx_a_tvalid_i   (tv),
        .tx_a_tready_i   (tr),
        .tx_a_tlast_i    (tl),
        .port_rst_n_o    (prst_n),
        .tx_block_o      (blk),
        .port_reset_ack_o(ack),
        .drain_timeout_o (dto)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Both ports leave rst_n together with req=0: 64 cycles in RESET, one in
    // HOLD, then RELEASE for 8 cycles before tx_block drops.
    task automatic check_power_on(input string tag);
        for (int k = 1; k <= 74; k++) begin
            tick();
            chk({tag, "_rst_n"}, prst_n, (k <= 64) ? 2'b00 : 2'b11);
            chk({tag, "_blk"},   blk,    (k <= 72) ? 2'b11 : 2'b00);
            chk({tag, "_ack"},   ack,    2'b00);
        end
        chk({tag, "_dto"}, dto, 2'b00);
    endtask

    // Idle-port request on port p; the other port must stay in RUN.
    task automatic seq_idle(input int p, input string tag);
        logic [NP-1:0] e_rst, e_blk, e_ack;
        req[p] = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            e_rst = 2'b11; e_blk = 2'b00; e_ack = 2'b00;
            e_blk[p] = 1'b1;
            e_rst[p] = (k >= 2) ? 1'b0 : 1'b1;
            e_ack[p] = (k >= 66) ? 1'b1 : 1'b0;
            chk({tag, "_rst_n"}, prst_n, e_rst);
            chk({tag, "_blk"},   blk,    e_blk);
            chk({tag, "_ack"},   ack,    e_ack);
        end
        req[p] = 1'b0;
        for (int k = 71; k <= 80; k++) begin
            tick();
            e_blk = 2'b00;
            e_blk[p] = (k < 79) ? 1'b1 : 1'b0;
            chk({tag, "_rel_rst_n"}, prst_n, 2'b11);
            chk({tag, "_rel_blk"},   blk,    e_blk);
            chk({tag, "_rel_ack"},   ack,    2'b00);
        end
    endtask

    initial begin
        // ---- 1: power-on --------------------------------------------------
        ticks(5);
        chk("rst_rst_n", prst_n, 2'b00);
        chk("rst_blk",   blk,    2'b11);
        chk("rst_ack",   ack,    2'b00);
        chk("rst_dto",   dto,    2'b00);
        rst_n = 1'b1;
        check_power_on("pwr");

        // ---- 2: idle request on port 0 -------------------------------------
        seq_idle(0, "idle0");

        // ---- 3: mid-packet drain on port 0, req dropped during DRAIN -------
        tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b0;
        tick();                                   // beat 1
        tick();                                   // beat 2
        chk("s3_pre_blk", blk, 2'b00);
        req[0] = 1'b1; tr[0] = 1'b0;
        tick();                                   // enter DRAIN
        chk("s3_drain_blk",   blk,    2'b01);
        chk("s3_drain_rst_n", prst_n, 2'b11);
        tick();
        req[0] = 1'b0;                            // must not abort the drain
        tick();
        tr[0] = 1'b1;
        tick();                                   // beat 3
        chk("s3_b3_rst_n", prst_n, 2'b11);
        tr[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s3_stall_rst_n", prst_n, 2'b11);
            chk("s3_stall_blk",   blk,    2'b01);
        end
        tr[0] = 1'b1; tl[0] = 1'b1;
        tick();                                   // beat 4 with tlast
        chk("s3_tlast_rst_n", prst_n, 2'b10);
        tv[0] = 1'b0; tr[0] = 1'b0; tl[0] = 1'b0;
        ticks(63);
        chk("s3_hold_end_rst_n", prst_n, 2'b10);
        tick();                                   // HOLD with req low
        chk("s3_hold_rst_n", prst_n, 2'b10);
        chk("s3_hold_ack",   ack,    2'b00);
        tick();                                   // RELEASE
        chk("s3_rel_rst_n", prst_n, 2'b11);
        chk("s3_rel_blk",   blk,    2'b01);
        ticks(7);
        chk("s3_gap_blk", blk, 2'b01);
        tick();
        chk("s3_run_blk", blk, 2'b00);

        // ---- 4: port 1 request while port 0 streams single-beat packets ---
        tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b1;
        seq_idle(1, "p1");
        tv[0] = 1'b0; tr[0] = 1'b0; tl[0] = 1'b0;

        // ---- 5: packet stuck open on port 0 --------------------------------
        tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b0;
        tick();                                   // opening beat, no tlast
        tv[0] = 1'b0; tr[0] = 1'b0;
        req[0] = 1'b1;
        tick();                                   // enter DRAIN
        chk("s5_drain_blk", blk, 2'b01);
`ifdef PORT_RST_DRAIN_TIMEOUT_EN
        ticks(15);
        chk("s5_pre_to_rst_n", prst_n, 2'b11);
        chk("s5_pre_to_dto",   dto,    2'b00);
        tick();                                   // 16 cycles after DRAIN
        chk("s5_to_rst_n", prst_n, 2'b10);
        chk("s5_to_dto",   dto,    2'b01);
        ticks(63);
        chk("s5_reset_dto", dto, 2'b01);
        tick();                                   // HOLD
        chk("s5_hold_ack", ack, 2'b01);
        chk("s5_hold_dto", dto, 2'b01);
        req[0] = 1'b0;
        tick();                                   // RELEASE
        chk("s5_rel_rst_n", prst_n, 2'b11);
        chk("s5_rel_dto",   dto,    2'b01);
        ticks(7);
        chk("s5_gap_dto", dto, 2'b01);
        chk("s5_gap_blk", blk, 2'b01);
        tick();                                   // RUN clears the flag
        chk("s5_run_dto", dto, 2'b00);
        chk("s5_run_blk", blk, 2'b00);
`else
        for (int k = 0; k < 39; k++) begin
            tick();
            chk("s5_wait_rst_n", prst_n, 2'b11);
            chk("s5_wait_dto",   dto,    2'b00);
        end
        tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b1;
        tick();                                   // closing beat
        chk("s5_close_rst_n", prst_n, 2'b10);
        tv[0] = 1'b0; tr[0] = 1'b0; tl[0] = 1'b0;
        req[0] = 1'b0;
        ticks(72);
        chk("s5_gap_blk", blk, 2'b01);
        tick();
        chk("s5_run_blk",   blk,    2'b00);
        chk("s5_run_rst_n", prst_n, 2'b11);
        chk("s5_run_dto",   dto,    2'b00);
`endif

        // ---- 6: asynchronous reset while both ports sit in HOLD ----------
        req = 2'b11;
        ticks(66);
        chk("s6_hold_ack",   ack,    2'b11);
        chk("s6_hold_rst_n", prst_n, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;                                       // no clock edge in between
        chk("s6_async_blk",   blk,    2'b11);
        chk("s6_async_rst_n", prst_n, 2'b00);
        chk("s6_async_ack",   ack,    2'b00);
        chk("s6_async_dto",   dto,    2'b00);
        tick();
        rst_n = 1'b1;
        req   = 2'b00;
        check_power_on("pwr2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
